rxuart_fifo: RTL and testbench



---
 rtl/rxuart_fifo.sv | 117 +++++++++++
 tb/tb_rxuart_fifo.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/rxuart_fifo.sv
// UART receive FWFT FIFO: a byte written at edge N is on o_data after edge N; a pop advances the head on the next edge.
// No backpressure toward the receiver: writes to a full FIFO without a same-cycle pop are dropped and flagged; optional idle timeout via RXUART_FIFO_TIMEOUT_EN.
module rxuart_fifo #(
   parameter int                      LGFLEN         = 4,
   parameter int                      TIMEOUT_BITS   = 14,
   parameter logic [TIMEOUT_BITS-1:0] TIMEOUT_CLOCKS = 14'd8680
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_wr,
   input  logic [7:0]        i_data,
   output logic              o_valid,
   output logic [7:0]        o_data,
   input  logic              i_ready,
   output logic [LGFLEN:0]   o_fill,
   output logic              o_half_full,
   output logic              o_overflow,
   input  logic              i_clear_overflow,
   output logic              o_timeout
);

   localparam int              DEPTH     = 1 << LGFLEN;
   localparam logic [LGFLEN:0] FULL_FILL = (LGFLEN+1)'(DEPTH);
   localparam logic [LGFLEN:0] HALF_FILL = (LGFLEN+1)'(DEPTH / 2);

   logic [7:0]        mem [DEPTH];
   logic [LGFLEN-1:0] wr_ptr;
   logic [LGFLEN-1:0] rd_ptr;
   logic [LGFLEN:0]   fill;
   logic              overflow;

   logic pop;
   logic wr_en;
   logic ovf_set;

   // A same-cycle pop frees the slot, so a full FIFO still accepts a write.
   assign pop     = o_valid && i_ready;
   assign wr_en   = i_wr && ((fill != FULL_FILL) || pop);
   assign ovf_set = i_wr && (fill == FULL_FILL) && !pop;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= 8'h00;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= i_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         fill <= '0;
      end else begin
         case ({wr_en, pop})
            2'b10:   fill <= fill + 1'b1;
            2'b01:   fill <= fill - 1'b1;
            default: fill <= fill;
         endcase
      end
   end

   // A drop in the same cycle as a clear request keeps the flag set.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         overflow <= 1'b0;
      end else if (ovf_set) begin
         overflow <= 1'b1;
      end else if (i_clear_overflow) begin
         overflow <= 1'b0;
      end
   end

   assign o_valid     = (fill != '0);
   assign o_data      = mem[rd_ptr];
   assign o_fill      = fill;
   assign o_half_full = (fill >= HALF_FILL);
   assign o_overflow  = overflow;

`ifdef RXUART_FIFO_TIMEOUT_EN
   localparam logic [TIMEOUT_BITS-1:0] TO_LOAD = TIMEOUT_CLOCKS - 1'b1;

   logic [TIMEOUT_BITS-1:0] to_cnt;
   logic                    to_flag;
   logic                    activity;

   assign activity = wr_en || pop;

   // Counter hits zero TIMEOUT_CLOCKS-1 edges after activity; the flag registers one edge later.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         to_cnt  <= TO_LOAD;
         to_flag <= 1'b0;
      end else begin
         if (activity || (fill == '0)) begin
            to_cnt <= TO_LOAD;
         end else if (to_cnt != '0) begin
            to_cnt <= to_cnt - 1'b1;
         end
         to_flag <= !activity && (to_cnt == '0) && (fill != '0);
      end
   end

   assign o_timeout = to_flag;
`else
   assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rxuart_fifo.sv
// Bench for rxuart_fifo: directed test-plan steps plus randomized traffic, all checked against a queue model.
module tb_rxuart_fifo;

   localparam int LGFLEN = 4;
   localparam int DEPTH  = 16;
   localparam int TO     = 20;

   logic              i_clk = 1'b0;
   logic              i_reset;
   logic              i_wr;
   logic [7:0]        i_data;
   logic              o_valid;
   logic [7:0]        o_data;
   logic              i_ready;
   logic [LGFLEN:0]   o_fill;
   logic              o_half_full;
   logic              o_overflow;
   logic              i_clear_overflow;
   logic              o_timeout;

   always #5 i_clk = ~i_clk;

   rxuart_fifo #(
      .LGFLEN         (LGFLEN),
      .TIMEOUT_BITS   (14),
      .TIMEOUT_CLOCKS (14'd20)
   ) dut (
      .i_clk            (i_clk),
      .i_reset          (i_reset),
      .i_wr             (i_wr),
      .i_data           (i_data),
      .o_valid          (o_valid),
      .o_data           (o_data),
      .i_ready          (i_ready),
      .o_fill           (o_fill),
      .o_half_full      (o_half_full),
      .o_overflow       (o_overflow),
      .i_clear_overflow (i_clear_overflow),
      .o_timeout        (o_timeout)
   );

   int         checks = 0;
   int         errors = 0;
   logic [7:0] q[$];
   logic       m_ovf = 1'b0;
   int         idle  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      logic exp_to;
`ifdef RXUART_FIFO_TIMEOUT_EN
      exp_to = (q.size() != 0) && (idle >= TO);
`else
      exp_to = 1'b0;
`endif
      chk("valid", 32'(o_valid), 32'(q.size() != 0));
      if (q.size() != 0) chk("data", 32'(o_data), 32'(q[0]));
      chk("fill", 32'(o_fill), 32'(q.size()));
      chk("half_full", 32'(o_half_full), 32'(q.size() >= DEPTH / 2));
      chk("overflow", 32'(o_overflow), 32'(m_ovf));
      chk("timeout", 32'(o_timeout), 32'(exp_to));
   endtask

   // Drive one cycle, advance the model by the FIFO rules, check after the edge.
   task automatic step(input logic wr, input logic [7:0] d, input logic rdy, input logic clr);
      logic pop, full, set, act;
      i_wr = wr; i_data = d; i_ready = rdy; i_clear_overflow = clr;
      pop  = rdy && (q.size() != 0);
      full = (q.size() == DEPTH);
      set  = 1'b0;
      act  = pop;
      @(posedge i_clk);
      if (pop) void'(q.pop_front());
      if (wr) begin
         if (!full || pop) begin
            q.push_back(d);
            act = 1'b1;
         end else begin
            set = 1'b1;
         end
      end
      if (set) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (act) idle = 0;
      else idle++;
      #1;
      check_all();
   endtask

   // Asynchronous reset pulse placed between clock edges; outputs checked before any edge.
   task automatic do_reset();
      i_reset = 1'b1;
      #2;
      q.delete();
      m_ovf = 1'b0;
      idle  = 0;
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_data", 32'(o_data), 32'h00);
      chk("rst_fill", 32'(o_fill), 32'd0);
      chk("rst_half", 32'(o_half_full), 32'd0);
      chk("rst_ovf", 32'(o_overflow), 32'd0);
      chk("rst_timeout", 32'(o_timeout), 32'd0);
      #1;
      i_reset = 1'b0;
   endtask

   initial begin
      i_reset = 1'b0; i_wr = 1'b0; i_data = 8'h00; i_ready = 1'b0; i_clear_overflow = 1'b0;
      do_reset();

      // Single byte latency and pop
      step(1'b1, 8'hA5, 1'b0, 1'b0);
      chk("first_byte", 32'(o_data), 32'hA5);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("empty_after_pop", 32'(o_valid), 32'd0);

      // Fill to full and overflow on the 17th write
      for (int i = 0; i < 17; i++) begin
         step(1'b1, 8'(i), 1'b0, 1'b0);
         if (i == 7) chk("half_at_8th", 32'(o_half_full), 32'd1);
         if (i == 6) chk("not_half_at_7th", 32'(o_half_full), 32'd0);
      end
      chk("full_fill", 32'(o_fill), 32'd16);
      chk("ovf_after_17", 32'(o_overflow), 32'd1);

      // Write+pop+clear while full
      step(1'b1, 8'h77, 1'b1, 1'b1);
      chk("full_wr_pop_fill", 32'(o_fill), 32'd16);
      chk("ovf_cleared", 32'(o_overflow), 32'd0);
      for (int i = 0; i < 16; i++) begin
         if (i == 15) chk("byte77_16th", 32'(o_data), 32'h77);
         else chk("drain_seq", 32'(o_data), 32'(i + 1));
         step(1'b0, 8'h00, 1'b1, 1'b0);
      end
      chk("drained", 32'(o_valid), 32'd0);

      // Steady streaming with pointer wrap
      for (int i = 0; i < 6; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
      for (int i = 0; i < 100; i++) step(1'b1, 8'(i + 100), 1'b1, 1'b0);
      chk("stream_fill", 32'(o_fill), 32'd6);
      chk("stream_no_ovf", 32'(o_overflow), 32'd0);
      for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

      // Reset in the middle of operation
      for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
      chk("pre_reset_fill", 32'(o_fill), 32'd9);
      do_reset();
      step(1'b1, 8'h3C, 1'b0, 1'b0);
      chk("post_reset_head", 32'(o_data), 32'h3C);

      // Idle timeout on the single buffered byte, then clear with a pop
      for (int i = 0; i < 24; i++) begin
         step(1'b0, 8'h00, 1'b0, 1'b0);
`ifdef RXUART_FIFO_TIMEOUT_EN
         if (i == 18) chk("timeout_not_yet", 32'(o_timeout), 32'd0);
         if (i == 19) chk("timeout_at_20", 32'(o_timeout), 32'd1);
`else
         if (i == 19) chk("timeout_absent", 32'(o_timeout), 32'd0);
`endif
      end
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("timeout_cleared", 32'(o_timeout), 32'd0);

      // Randomized traffic: slow consumer first, then fast consumer
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), 8'($urandom),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
      end
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 2) == 0), 8'($urandom),
              ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
